// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder family.
//   cla_pg_t          : propagate/generate pair for one bit or one group
//   CLA_GROUP_DEFAULT : default lookahead group width
//   groups_per_stage  : ceiling divide used to spread groups across stages
package cla_pkg;

  localparam int CLA_GROUP_DEFAULT = 4;

  typedef struct packed {
    logic p;
    logic g;
  } cla_pg_t;

  function automatic int groups_per_stage(input int ng, input int stages);
    return (ng + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead block.
// Ports:
//   a, b  in  GROUP  operand bits (b already inverted for subtract)
//   cin   in  1      carry into bit 0 of the group
//   sum   out GROUP  group sum bits
//   gp    out 1      group propagate (AND of bit propagates)
//   gg    out 1      group generate (lookahead form)
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP_DEFAULT
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             gp,
  output logic             gg
);

  cla_pg_t [GROUP-1:0] w_pg;
  logic    [GROUP-1:0] w_c;

  // Group P/G depend only on a/b, never on cin. Keeping them in their own
  // block stops the simulator from seeing a false loop through the
  // inter-group lookahead in the parent.
  always_comb begin
    logic prod;
    gg   = 1'b0;
    prod = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      w_pg[i].p = a[i] ^ b[i];
      w_pg[i].g = a[i] & b[i];
    end
    for (int m = GROUP - 1; m >= 0; m--) begin
      gg   = gg | (w_pg[m].g & prod);
      prod = prod & w_pg[m].p;
    end
    gp = prod;
  end

  // Every bit carry is a flat sum of products back to cin; no bit ripple.
  always_comb begin
    logic c;
    logic prod;
    w_c = '0;
    for (int i = 0; i < GROUP; i++) begin
      c    = 1'b0;
      prod = 1'b1;
      for (int m = GROUP - 1; m >= 0; m--) begin
        if (m < i) begin
          c    = c | (w_pg[m].g & prod);
          prod = prod & w_pg[m].p;
        end
      end
      w_c[i] = c | (prod & cin);
    end
  end

  always_comb begin
    for (int i = 0; i < GROUP; i++) begin
      sum[i] = w_pg[i].p ^ w_c[i];
    end
  end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Ports:
//   Clk        in   1      clock, rising edge
//   Reset      in   1      synchronous active-high reset
//   in_valid   in   1      operand beat present
//   in_ready   out  1      beat accepted this cycle
//   A, B       in   WIDTH  operands
//   Sub        in   1      0: A+B, 1: A-B
//   out_valid  out  1      result beat present
//   out_ready  in   1      consumer accepts result
//   Sum        out  WIDTH  result mod 2^WIDTH
//   CO         out  1      carry out of MSB (subtract: 1 = no borrow)
//   OV         out  1      signed overflow
// Groups are split ceil(NG/STAGES) per stage, low groups first. Each stage
// finishes its groups' sum bits and forwards the carry into the next group.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int GROUP  = CLA_GROUP_DEFAULT,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             OV
);

  localparam int NG   = WIDTH / GROUP;
  localparam int GPS  = groups_per_stage(NG, STAGES);
  localparam int LAST = STAGES - 1;
  // Intermediate register count; kept at least 1 so the single-stage
  // configuration still declares legal arrays.
  localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;

  if (WIDTH % GROUP != 0) begin : g_bad_width
    $fatal(1, "pipelined_cla_addsub: WIDTH must be a multiple of GROUP");
  end
  if (STAGES < 1 || STAGES > NG) begin : g_bad_stages
    $fatal(1, "pipelined_cla_addsub: STAGES must be in 1..WIDTH/GROUP");
  end

  // Handshake
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] w_ld;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_up_vld;
  logic [STAGES-1:0] w_en;

  // Per-stage view of the operands and partial sum
  logic [WIDTH-1:0]  w_a_in    [STAGES];
  logic [WIDTH-1:0]  w_b_in    [STAGES];
  logic [WIDTH-1:0]  w_sum_in  [STAGES];
  logic [WIDTH-1:0]  w_sum_out [STAGES];
  logic [STAGES-1:0] w_cin_st;
  logic [STAGES-1:0] w_cout_st;

  // Intermediate stage registers (data only, no reset)
  logic [WIDTH-1:0]  r_a   [NMID];
  logic [WIDTH-1:0]  r_b   [NMID];
  logic [WIDTH-1:0]  r_sum [NMID];
  logic [NMID-1:0]   r_c;

  // Group signals
  logic [NG-1:0]     w_gp;
  logic [NG-1:0]     w_gg;
  logic [NG-1:0]     w_gcin;
  logic [WIDTH-1:0]  w_gsum;

  // Output registers
  logic [WIDTH-1:0]  r_sum_o;
  logic              r_co;
  logic              r_ov;

  // Carry into group hi given the carry into group lo, as a flat
  // sum of products over the intervening group P/G terms.
  function automatic logic la_carry(input logic [NG-1:0] gp,
                                    input logic [NG-1:0] gg,
                                    input logic          cin,
                                    input int            lo,
                                    input int            hi);
    logic c;
    logic prod;
    c    = 1'b0;
    prod = 1'b1;
    for (int m = NG - 1; m >= 0; m--) begin
      if (m >= lo && m < hi) begin
        c    = c | (gg[m] & prod);
        prod = prod & gp[m];
      end
    end
    return c | (prod & cin);
  endfunction

  // Elastic chain: walk from the output back to the input so each stage
  // knows whether its downstream neighbour frees up this cycle.
  always_comb begin
    logic down;
    w_adv    = '0;
    w_ld     = '0;
    w_up_vld = '0;
    down     = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = r_vld[k] & down;
      w_ld[k]  = ~r_vld[k] | w_adv[k];
      down     = w_ld[k];
    end
    w_up_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_up_vld[k] = r_vld[k-1];
    end
    w_en = w_ld & w_up_vld;
  end

  assign in_ready  = w_ld[0];
  assign out_valid = r_vld[LAST];
  assign Sum       = r_sum_o;
  assign CO        = r_co;
  assign OV        = r_ov;

  // Stage inputs: stage 0 takes the ports, later stages their predecessor.
  // Sub only matters as the carry into group 0, so it is folded into the
  // forwarded carry rather than carried along separately.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
    if (k == 0) begin : g_first
      assign w_a_in[0]   = A;
      assign w_b_in[0]   = Sub ? ~B : B;
      assign w_sum_in[0] = '0;
      assign w_cin_st[0] = Sub;
    end else begin : g_later
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_sum_in[k] = r_sum[k-1];
      assign w_cin_st[k] = r_c[k-1];
    end
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int S = g / GPS;
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (w_a_in[S][g*GROUP +: GROUP]),
      .b   (w_b_in[S][g*GROUP +: GROUP]),
      .cin (w_gcin[g]),
      .sum (w_gsum[g*GROUP +: GROUP]),
      .gp  (w_gp[g]),
      .gg  (w_gg[g])
    );
  end

  // Lookahead across the groups owned by each stage.
  always_comb begin
    w_gcin    = '0;
    w_cout_st = '0;
    for (int g = 0; g < NG; g++) begin
      w_gcin[g] = la_carry(w_gp, w_gg, w_cin_st[g/GPS], (g/GPS)*GPS, g);
    end
    for (int s = 0; s < STAGES; s++) begin
      w_cout_st[s] = la_carry(w_gp, w_gg, w_cin_st[s], s*GPS, (s+1)*GPS);
    end
  end

  // Each stage overwrites only its own groups' bits of the partial sum.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_sum_out[s] = w_sum_in[s];
    end
    for (int g = 0; g < NG; g++) begin
      w_sum_out[g/GPS][g*GROUP +: GROUP] = w_gsum[g*GROUP +: GROUP];
    end
  end

  // ---- stage boundaries 0..STAGES-2: partial sum, next carry, operands ----
  always_ff @(posedge Clk) begin
    for (int k = 0; k < LAST; k++) begin
      if (w_en[k]) begin
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_sum[k] <= w_sum_out[k];
        r_c[k]   <= w_cout_st[k];
      end
    end
  end

  // ---- final stage boundary: Sum, CO, OV ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sum_o <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
    end else if (w_en[LAST]) begin
      r_sum_o <= w_sum_out[LAST];
      r_co    <= w_cout_st[LAST];
      r_ov    <= (w_a_in[LAST][WIDTH-1] == w_b_in[LAST][WIDTH-1]) &&
                 (w_sum_out[LAST][WIDTH-1] != w_a_in[LAST][WIDTH-1]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ld[k]) r_vld[k] <= w_up_vld[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub at WIDTH=16, GROUP=4, STAGES=2.
module tb_pipelined_cla_addsub;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Sum;
  logic        CO;
  logic        OV;

  int n_cmp  = 0;
  int n_fail = 0;

  pipelined_cla_addsub #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .CO        (CO),
    .OV        (OV)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated beat; checks latency is exactly two cycles.
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] e_sum, input logic e_co,
                         input logic e_ov);
    @(negedge Clk);
    A = a; B = b; Sub = sub; in_valid = 1'b1;
    #1 chk({tag, ".in_ready"}, in_ready, 1);
    @(negedge Clk);
    in_valid = 1'b0;
    chk({tag, ".early_valid"}, out_valid, 0);
    @(negedge Clk);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".Sum"}, Sum, e_sum);
    chk({tag, ".CO"}, CO, e_co);
    chk({tag, ".OV"}, OV, e_ov);
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] held;
    int          next_beat;
    int          popped;
    int          occ;
    int          stall_left;
    logic        got_first;
    logic        in_x;
    logic        out_x;

    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Sub = 1'b0;
    repeat (2) @(negedge Clk);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.Sum", Sum, 0);
    chk("reset.CO", CO, 0);
    chk("reset.OV", OV, 0);
    Reset = 1'b0;

    // Single-beat arithmetic
    run_one("add_basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_one("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("add_xgrp",   16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_one("add_negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("sub_zero",   16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Back-to-back stream: beat c drives A=B=c+1, appears two cycles later
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (c < 8) begin
        A = 16'(c + 1); B = 16'(c + 1); Sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 8) chk("stream.in_ready", in_ready, 1);
      if (c >= 2) begin
        chk("stream.out_valid", out_valid, 1);
        chk("stream.Sum", Sum, 2 * (c - 1));
      end else begin
        chk("stream.idle", out_valid, 0);
      end
    end
    @(negedge Clk);
    chk("stream.drained", out_valid, 0);

    // Backpressure: 5 beats, out_ready low for 3 cycles after first result
    next_beat = 1; popped = 0; occ = 0; stall_left = 0; got_first = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && popped < 5; cyc++) begin
      @(negedge Clk);
      out_ready = (stall_left == 0);
      if (next_beat <= 5) begin
        A = 16'(next_beat * 16'h0100); B = 16'(next_beat); Sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && occ == 2) chk("bp.in_ready_full", in_ready, 0);
      if (out_ready) chk("bp.in_ready_flow", in_ready, 1);
      if (stall_left > 0) begin
        chk("bp.stall_valid", out_valid, 1);
        if (stall_left == 3) held = Sum;
        else chk("bp.stall_hold", Sum, held);
      end
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        if (exp_q.size() == 0) begin
          chk("bp.unexpected_out", 1, 0);
        end else begin
          chk("bp.order_Sum", Sum, exp_q.pop_front());
          chk("bp.CO", CO, 0);
        end
        popped++;
        if (!got_first) begin
          got_first  = 1'b1;
          stall_left = 3;
        end
      end else if (stall_left > 0) begin
        stall_left--;
      end
      if (in_x) begin
        exp_q.push_back(16'(next_beat * 16'h0101));
        next_beat++;
      end
      occ = occ + int'(in_x) - int'(out_x);
    end
    chk("bp.delivered", popped, 5);
    out_ready = 1'b1;
    in_valid  = 1'b0;

    // Reset with two beats in flight
    @(negedge Clk);
    A = 16'hFFFF; B = 16'hFFFF; Sub = 1'b0; in_valid = 1'b1;
    @(negedge Clk);
    A = 16'h0102; B = 16'h0304;
    @(negedge Clk);
    chk("rst_mid.pre_valid", out_valid, 1);
    chk("rst_mid.pre_Sum", Sum, 16'hFFFE);
    chk("rst_mid.pre_CO", CO, 1);
    Reset = 1'b1; A = 16'h5555; B = 16'h1111;
    @(negedge Clk);
    chk("rst_mid.out_valid", out_valid, 0);
    chk("rst_mid.Sum", Sum, 0);
    chk("rst_mid.CO", CO, 0);
    chk("rst_mid.OV", OV, 0);
    Reset = 1'b0; in_valid = 1'b0;
    @(negedge Clk);
    chk("rst_mid.no_stale1", out_valid, 0);
    @(negedge Clk);
    chk("rst_mid.no_stale2", out_valid, 0);
    run_one("post_reset", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. Operand width, lookahead group size and pipeline depth are parameters. The block adds signed overflow, subtract mode, backpressure and register stages to the team's combinational 16-bit CLA. It sits between operand sources (register file / datapath muxes) and the result bus, and can be retimed by changing STAGES.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
GROUP, 4, bits per lookahead group (per-group P/G generation, ripple-free carry inside the group).
STAGES, 2, number of register stages, 1..WIDTH/GROUP; also the latency in cycles.

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
in_valid  in  1  operand beat present
in_ready  out  1  block accepts beat this cycle
A  in  WIDTH  operand A
B  in  WIDTH  operand B
Sub  in  1  0: A+B, 1: A-B
out_valid  out  1  result beat present
out_ready  in  1  consumer accepts result
Sum  out  WIDTH  result, mod 2^WIDTH
CO  out  1  carry out of MSB (in subtract mode, 1 = no borrow)
OV  out  1  two's-complement signed overflow

Behaviour:
- Arithmetic: Beff = Sub ? ~B : B, carry-in = Sub. Sum = (A + Beff + Sub) mod 2^WIDTH. CO = bit WIDTH of that sum. OV = (A[MSB] == Beff[MSB]) && (Sum[MSB] != A[MSB]).
- Carry structure: NG = WIDTH/GROUP groups. Each group produces a group propagate (AND of bit P) and a group generate (standard lookahead form). Inter-group carries use lookahead across groups, never ripple between bits.
- Pipeline partition: groups are split evenly across stages, ceil(NG/STAGES) per stage, with the low groups in stage 0.
  - Stage k registers the finished low Sum bits, the carry into the next group, and the untouched upper A/Beff bits plus Sub.
  - The final stage registers Sum, CO and OV.
- Handshake: transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- Elastic pipeline: each stage holds a valid bit. A stage loads when it is empty or its contents move downstream in the same cycle.
- in_ready = !v[0] || stage 0 advances. This is combinational from out_ready through the stage chain; no combinational path exists from in_valid to out_valid.
- Latency: exactly STAGES cycles from input acceptance to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Full pipe: STAGES beats in flight with out_ready low gives in_ready = 0. Data is never dropped or duplicated, and order is preserved.
- Stall: while out_valid && !out_ready, Sum/CO/OV/out_valid hold stable.
- Simultaneous accept and emit on a full pipe: both occur in the same cycle and occupancy stays unchanged.
- Reset (at any time, including mid-stream): on the next edge all valid bits = 0 and Sum/CO/OV = 0. out_valid = 0 in the cycle after Reset is sampled. In-flight beats are discarded.
- in_ready while Reset is asserted: 1 is permitted, but beats presented during Reset are dropped.
- Registers without a valid bit need no reset, except the output registers, which reset to 0.
- Boundary: WIDTH == GROUP with STAGES = 1 is a legal degenerate single-group configuration. Elaboration must fail (assertion) if WIDTH % GROUP != 0 or STAGES is out of range.

Decomposition:
- Shared package cla_pkg:
  - typedef for group P/G pair.
  - Localparam helper function for groups-per-stage (ceil divide).
  - GROUP default constant.
- Sub-module cla_group (GROUP-bit block): inputs a, b, cin; outputs sum, gp, gg. It is instantiated NG times.
- Top-level holds the lookahead carry logic and stage registers.

Test Plan (WIDTH=16, GROUP=4, STAGES=2, out_ready=1 unless stated):
1. A=0x1234, B=0x4321, Sub=0 -> 2 cycles later Sum=0x5555, CO=0, OV=0.
2. A=0xFFFF, B=0x0001, Sub=0 -> Sum=0x0000, CO=1, OV=0. A=0x7FFF, B=0x0001 -> Sum=0x8000, CO=0, OV=1.
3. Sub: A=0x0005, B=0x0007 -> Sum=0xFFFE, CO=0, OV=0. A=0x8000, B=0x0001 -> Sum=0x7FFF, CO=1, OV=1.
4. Stream 0x0001+0x0001 through 0x0008+0x0008 back-to-back -> outputs 0x0002..0x0010, one per cycle, starting at cycle 2.
5. Backpressure: stream 5 beats, drop out_ready for 3 cycles after the first result -> in_ready=0 once 2 beats are held, outputs stable while stalled, all 5 results delivered in order.
6. Reset asserted while 2 beats are in flight -> next cycle out_valid=0 and Sum=0. The next beat after Reset deasserts emerges with latency 2, with no stale data.
